// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scanner for a common-anode 7-segment display with per-slot anode-off gap.
// Registered outputs; shadow value captured on load, sampled once per slot at the GAP->SHOW edge.
module seven_seg_scanner #(
   parameter int DIGITS      = 4,
   parameter int SLOT_CYCLES = 50000,
   parameter int GAP_CYCLES  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_lz,
   output logic [3:0]            bin,
   output logic [DIGITS-1:0]     an_n,
   output logic                  dp_n,
   output logic [2:0]            digit_idx,
   output logic                  frame_done
);

   localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);

   typedef enum logic [1:0] {S_OFF, S_GAP, S_SHOW} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2:0]          idx_q, idx_d;
   logic [4*DIGITS-1:0] val_q, val_d;
   logic [DIGITS-1:0]   dpsh_q, dpsh_d;
   logic [3:0]          bin_q, bin_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                dpn_q, dpn_d;
   logic                fd_q, fd_d;

   logic                capture, slot_end, stop, gap_last, last_digit;
   logic [3:0]          cur_nib;
   logic                cur_dp, cur_nz, lit;
   logic [DIGITS-1:0]   nz_above, onehot_n;

   assign gap_last   = (GAP_CYCLES == 0) || (int'(cnt_q) == GAP_CYCLES - 1);
   assign last_digit = (int'(idx_q) == DIGITS - 1);

   // Shadow registers accept a load in every state; the slot in progress keeps its captured copy.
   always_comb begin
      val_d  = load ? value_in : val_q;
      dpsh_d = load ? dp_in    : dpsh_q;
   end

   // nz_above[i]: some digit at or above i has a non-zero nibble or a lit dp.
   always_comb begin
      logic acc;
      acc      = 1'b0;
      nz_above = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         acc         = acc | (|val_q[4*i +: 4]) | dpsh_q[i];
         nz_above[i] = acc;
      end
   end

   always_comb begin
      cur_nib  = 4'h0;
      cur_dp   = 1'b0;
      cur_nz   = 1'b0;
      onehot_n = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (int'(idx_q) == i) begin
            cur_nib     = val_q[4*i +: 4];
            cur_dp      = dpsh_q[i];
            cur_nz      = nz_above[i];
            onehot_n[i] = 1'b0;
         end
      end
      lit = !(blank_lz && (idx_q != 3'd0) && !cur_nz);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         idx_q   <= '0;
         val_q   <= '0;
         dpsh_q  <= '0;
         bin_q   <= '0;
         an_q    <= '1;
         dpn_q   <= 1'b1;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
         dpsh_q  <= dpsh_d;
         bin_q   <= bin_d;
         an_q    <= an_d;
         dpn_q   <= dpn_d;
         fd_q    <= fd_d;
      end
   end

   // With no gap, the first slot lights at once; later slots still spend the boundary cycle dark.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      capture  = 1'b0;
      slot_end = 1'b0;
      stop     = 1'b0;
      case (state_q)
         S_OFF: begin
            if (enable) begin
               cnt_d = '0;
               idx_d = '0;
               if (GAP_CYCLES == 0) begin
                  state_d = S_SHOW;
                  capture = 1'b1;
               end else begin
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (!enable) begin
               stop = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (gap_last) begin
                  state_d = S_SHOW;
                  capture = 1'b1;
               end
            end
         end
         S_SHOW: begin
            if (!enable) begin
               stop = 1'b1;
            end else if (cnt_q == SLOT_LAST) begin
               cnt_d    = '0;
               idx_d    = last_digit ? 3'd0 : idx_q + 3'd1;
               state_d  = S_GAP;
               slot_end = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: stop = 1'b1;
      endcase
      if (stop) begin
         state_d = S_OFF;
         cnt_d   = '0;
         idx_d   = '0;
      end
   end

   always_comb begin
      bin_d = bin_q;
      an_d  = an_q;
      dpn_d = dpn_q;
      fd_d  = slot_end && last_digit;
      if (state_d == S_OFF) begin
         bin_d = 4'h0;
         an_d  = '1;
         dpn_d = 1'b1;
         fd_d  = 1'b0;
      end else if (capture) begin
         bin_d = cur_nib;
         an_d  = lit ? onehot_n : '1;
         dpn_d = lit ? ~cur_dp : 1'b1;
      end else if (state_d == S_GAP) begin
         an_d  = '1;
         dpn_d = 1'b1;
      end
   end

   assign bin        = bin_q;
   assign an_n       = an_q;
   assign dp_n       = dpn_q;
   assign digit_idx  = idx_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a gapped (GAP=2) and a gapless (GAP=0) instance share stimulus;
// a time-since-enable reference model tracks both.
module tb_seven_seg_scanner;
   localparam int D = 4;
   localparam int S = 8;

   logic        clk = 1'b0;
   logic        rst_n, enable, load, blank_lz;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic [3:0]  bin0, bin1, an0, an1;
   logic        dpn0, dpn1, fd0, fd1;
   logic [2:0]  idx0, idx1;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   seven_seg_scanner #(.DIGITS(D), .SLOT_CYCLES(S), .GAP_CYCLES(2)) u0 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value_in(value_in),
      .dp_in(dp_in), .blank_lz(blank_lz), .bin(bin0), .an_n(an0), .dp_n(dpn0),
      .digit_idx(idx0), .frame_done(fd0));

   seven_seg_scanner #(.DIGITS(D), .SLOT_CYCLES(S), .GAP_CYCLES(0)) u1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value_in(value_in),
      .dp_in(dp_in), .blank_lz(blank_lz), .bin(bin1), .an_n(an1), .dp_n(dpn1),
      .digit_idx(idx1), .frame_done(fd1));

   // Reference model: position within the scan is derived from cycles since enable.
   bit          running[2];
   int          t[2];
   logic [3:0]  mbin[2], man[2];
   logic        mdpn[2], mfd[2];
   logic [2:0]  midx[2];
   logic [15:0] sval;
   logic [3:0]  sdp;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         running[i] = 0; t[i] = 0; mbin[i] = 4'h0; man[i] = 4'hF;
         mdpn[i] = 1'b1; mfd[i] = 1'b0; midx[i] = 3'd0;
      end
      sval = 16'h0; sdp = 4'h0;
   endtask

   function automatic int highest();
      int h = 0;
      for (int j = 0; j < D; j++)
         if (((sval >> (4*j)) & 16'hF) != 16'h0 || sdp[j]) h = j;
      return h;
   endfunction

   task automatic model_edge();
      int g, p, slot;
      bit cap;
      for (int i = 0; i < 2; i++) begin
         g = (i == 0) ? 2 : 0;
         mfd[i] = 1'b0;
         if (!enable) begin
            running[i] = 0; t[i] = 0; mbin[i] = 4'h0; man[i] = 4'hF;
            mdpn[i] = 1'b1; midx[i] = 3'd0;
         end else begin
            if (!running[i]) begin running[i] = 1; t[i] = 0; end
            else t[i] = t[i] + 1;
            p = t[i] % S;
            slot = (t[i] / S) % D;
            midx[i] = 3'(slot);
            mfd[i] = (t[i] > 0) && (t[i] % (S*D) == 0);
            cap = (g > 0) ? (p == g) : (t[i] == 0 || (p == 1 && t[i] >= S));
            if (cap) begin
               mbin[i] = 4'((sval >> (4*slot)) & 16'hF);
               if (blank_lz && slot > highest()) begin
                  man[i] = 4'hF; mdpn[i] = 1'b1;
               end else begin
                  man[i] = ~(4'(1) << slot); mdpn[i] = ~sdp[slot];
               end
            end else if (p < g || p == 0) begin
               man[i] = 4'hF; mdpn[i] = 1'b1;
            end
         end
      end
      if (load) begin sval = value_in; sdp = dp_in; end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic load_value(input logic [15:0] v, input logic [3:0] d);
      value_in = v; dp_in = d; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; load = 1'b0; blank_lz = 1'b0;
      value_in = 16'h0; dp_in = 4'h0;
      model_reset();
      #12;
      n_total++;
      if ({bin0, an0, dpn0, fd0, idx0} !== {4'h0, 4'hF, 1'b1, 1'b0, 3'd0}) begin
         n_bad++; $display("FAIL reset_u0 got=%h exp=%h", {bin0, an0, dpn0, fd0, idx0}, {4'h0, 4'hF, 1'b1, 1'b0, 3'd0});
      end
      n_total++;
      if ({bin1, an1, dpn1, fd1, idx1} !== {4'h0, 4'hF, 1'b1, 1'b0, 3'd0}) begin
         n_bad++; $display("FAIL reset_u1 got=%h exp=%h", {bin1, an1, dpn1, fd1, idx1}, {4'h0, 4'hF, 1'b1, 1'b0, 3'd0});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_scan();
      logic [3:0] exp_an[4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
      logic [3:0] exp_bin[4] = '{4'h4, 4'h3, 4'h2, 4'h1};
      load_value(16'h1234, 4'h0);
      enable = 1'b1;
      for (int e = 0; e <= 33; e++) begin
         step();
         if (e >= 2 && (e - 2) % 8 == 0) begin
            n_total++;
            if ({an0, bin0, dpn0} !== {exp_an[(e-2)/8], exp_bin[(e-2)/8], 1'b1}) begin
               n_bad++; $display("FAIL basic_digit e=%0d got an=%h bin=%h dp_n=%b exp an=%h bin=%h dp_n=1",
                                 e, an0, bin0, dpn0, exp_an[(e-2)/8], exp_bin[(e-2)/8]);
            end
         end
         if (e >= 31) begin
            n_total++;
            if (fd0 !== (e == 32)) begin
               n_bad++; $display("FAIL basic_frame_done e=%0d got=%b exp=%b", e, fd0, e == 32);
            end
         end
      end
      enable = 1'b0; step();
   endtask

   task automatic test_blank();
      logic [15:0] vals[3]   = '{16'h0050, 16'h0000, 16'h0050};
      logic [3:0]  dps[3]    = '{4'h0, 4'h0, 4'b0100};
      logic [3:0]  exp_an[3][4] = '{'{4'hE, 4'hD, 4'hF, 4'hF},
                                    '{4'hE, 4'hF, 4'hF, 4'hF},
                                    '{4'hE, 4'hD, 4'hB, 4'hF}};
      logic [3:0]  exp_bin[3][4] = '{'{4'h0, 4'h5, 4'h0, 4'h0},
                                     '{4'h0, 4'h0, 4'h0, 4'h0},
                                     '{4'h0, 4'h5, 4'h0, 4'h0}};
      int d;
      logic edp;
      blank_lz = 1'b1;
      for (int c = 0; c < 3; c++) begin
         load_value(vals[c], dps[c]);
         enable = 1'b1;
         for (int e = 0; e <= 26; e++) begin
            step();
            if (e >= 2 && (e - 2) % 8 == 0) begin
               d = (e - 2) / 8;
               edp = !(c == 2 && d == 2);
               n_total++;
               if ({an0, bin0, dpn0} !== {exp_an[c][d], exp_bin[c][d], edp}) begin
                  n_bad++; $display("FAIL blank case=%0d digit=%0d got an=%h bin=%h dp_n=%b exp an=%h bin=%h dp_n=%b",
                                    c, d, an0, bin0, dpn0, exp_an[c][d], exp_bin[c][d], edp);
               end
            end
         end
         enable = 1'b0; step();
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_load_mid();
      load_value(16'h1234, 4'h0);
      enable = 1'b1;
      for (int e = 0; e <= 10; e++) begin
         if (e == 3) begin value_in = 16'hABCD; load = 1'b1; end
         step();
         load = 1'b0;
         if (e >= 3 && e <= 7) begin
            n_total++;
            if ({an0, bin0} !== {4'hE, 4'h4}) begin
               n_bad++; $display("FAIL load_mid_hold e=%0d got an=%h bin=%h exp an=e bin=4", e, an0, bin0);
            end
         end
         if (e == 10) begin
            n_total++;
            if ({an0, bin0} !== {4'hD, 4'hC}) begin
               n_bad++; $display("FAIL load_mid_next got an=%h bin=%h exp an=d bin=c", an0, bin0);
            end
         end
      end
      enable = 1'b0; step();
   endtask

   task automatic test_enable_drop();
      load_value(16'h1234, 4'h0);
      enable = 1'b1;
      for (int e = 0; e <= 20; e++) step();
      enable = 1'b0;
      step();
      n_total++;
      if ({an0, bin0, idx0, dpn0} !== {4'hF, 4'h0, 3'd0, 1'b1}) begin
         n_bad++; $display("FAIL enable_drop got an=%h bin=%h idx=%0d dp_n=%b exp an=f bin=0 idx=0 dp_n=1", an0, bin0, idx0, dpn0);
      end
      enable = 1'b1;
      step(); step();
      n_total++;
      if (an0 !== 4'hF) begin
         n_bad++; $display("FAIL reenable_gap got an=%h exp=f", an0);
      end
      step();
      n_total++;
      if ({an0, bin0} !== {4'hE, 4'h4}) begin
         n_bad++; $display("FAIL reenable_first got an=%h bin=%h exp an=e bin=4", an0, bin0);
      end
      enable = 1'b0; step();
   endtask

   task automatic test_async_reset();
      load_value(16'h1234, 4'h0);
      enable = 1'b1;
      for (int e = 0; e <= 12; e++) step();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_total++;
      if ({bin0, an0, dpn0, fd0, idx0} !== {4'h0, 4'hF, 1'b1, 1'b0, 3'd0}) begin
         n_bad++; $display("FAIL async_reset got=%h exp=%h", {bin0, an0, dpn0, fd0, idx0}, {4'h0, 4'hF, 1'b1, 1'b0, 3'd0});
      end
      #2 rst_n = 1'b1;
      step(); step(); step();
      n_total++;
      if ({an0, bin0, dpn0, idx0} !== {4'hE, 4'h0, 1'b1, 3'd0}) begin
         n_bad++; $display("FAIL post_reset_scan got an=%h bin=%h dp_n=%b idx=%0d exp an=e bin=0 dp_n=1 idx=0", an0, bin0, dpn0, idx0);
      end
      enable = 1'b0; step();
   endtask

   task automatic test_no_gap();
      load_value(16'h1234, 4'h0);
      enable = 1'b1;
      step();
      n_total++;
      if ({an1, bin1, an0} !== {4'hE, 4'h4, 4'hF}) begin
         n_bad++; $display("FAIL no_gap_first got an1=%h bin1=%h an0=%h exp an1=e bin1=4 an0=f", an1, bin1, an0);
      end
      for (int e = 1; e <= 9; e++) begin
         step();
         if (e == 7 || e == 8) begin
            n_total++;
            if (an1 !== ((e == 7) ? 4'hE : 4'hF)) begin
               n_bad++; $display("FAIL no_gap_boundary e=%0d got=%h exp=%h", e, an1, (e == 7) ? 4'hE : 4'hF);
            end
         end
      end
      n_total++;
      if ({an1, bin1} !== {4'hD, 4'h3}) begin
         n_bad++; $display("FAIL no_gap_next got an=%h bin=%h exp an=d bin=3", an1, bin1);
      end
      enable = 1'b0; step();
   endtask

   task automatic test_random();
      logic [15:0] v;
      enable = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         for (int j = 0; j < 4; j++) v[4*j +: 4] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
         value_in = v;
         dp_in    = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
         load     = ($urandom % 8 == 0);
         if ($urandom % 50 == 0) blank_lz = ~blank_lz;
         if (enable) enable = ($urandom % 300 != 0);
         else        enable = ($urandom % 5 == 0);
         step();
         n_total++;
         if ({bin0, an0, dpn0, fd0, idx0} !== {mbin[0], man[0], mdpn[0], mfd[0], midx[0]}) begin
            n_bad++; $display("FAIL random_u0 n=%0d got=%h exp=%h", n, {bin0, an0, dpn0, fd0, idx0}, {mbin[0], man[0], mdpn[0], mfd[0], midx[0]});
         end
         n_total++;
         if ({bin1, an1, dpn1, fd1, idx1} !== {mbin[1], man[1], mdpn[1], mfd[1], midx[1]}) begin
            n_bad++; $display("FAIL random_u1 n=%0d got=%h exp=%h", n, {bin1, an1, dpn1, fd1, idx1}, {mbin[1], man[1], mdpn[1], mfd[1], midx[1]});
         end
      end
      load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_blank();
      test_load_mid();
      test_enable_drop();
      test_async_reset();
      test_no_gap();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
